// File: rtl/param_stack.sv
// Parametrised LIFO stack: single-cycle push, pop and replace (push+pop).
// Combinational top-of-stack, registered pop data, sticky error flags.
module param_stack #(
   parameter  int WIDTH = 24,
   parameter  int DEPTH = 256,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_dout;
   logic             r_dv;
   logic             r_ovf;
   logic             r_unf;

   logic             w_empty;
   logic             w_full;
   logic [CW-1:0]    w_top_idx;
   logic [AW-1:0]    w_top_addr;
   logic [AW-1:0]    w_waddr;
   logic             w_repl;
   logic             w_push_only;
   logic             w_pop_only;
   logic             w_we;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CW'(DEPTH));
   assign w_top_idx  = r_count - CW'(1);
   assign w_top_addr = w_top_idx[AW-1:0];

   // push+pop on an empty stack degrades to a plain push
   assign w_repl      = push & pop & ~w_empty;
   assign w_push_only = push & ~w_repl & ~w_full;
   assign w_pop_only  = pop & ~push & ~w_empty;
   assign w_we        = ~clear & (w_repl | w_push_only);
   assign w_waddr     = w_repl ? w_top_addr : r_count[AW-1:0];

   always_ff @(posedge clk) begin
      if (w_we && !reset) begin
         r_mem[w_waddr] <= din;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_dout  <= '0;
         r_dv    <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (clear) begin
         r_count <= '0;
         r_dv    <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_dv <= w_repl | w_pop_only;
         if (w_repl || w_pop_only) begin
            r_dout <= r_mem[w_top_addr];
         end
         if (w_push_only) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop_only) begin
            r_count <= r_count - CW'(1);
         end
         if (push && !pop && w_full) begin
            r_ovf <= 1'b1;
         end
         if (pop && !push && w_empty) begin
            r_unf <= 1'b1;
         end
      end
   end

   assign top        = w_empty ? '0 : r_mem[w_top_addr];
   assign dout       = r_dout;
   assign dout_valid = r_dv;
   assign count      = r_count;
   assign empty      = w_empty;
   assign full       = w_full;
   assign overflow   = r_ovf;
   assign underflow  = r_unf;

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack (WIDTH=24, DEPTH=5): directed
// vectors with hand-computed results, then random traffic vs a queue model.
`timescale 1ns/1ps
module tb_param_stack;

   localparam int W = 24;
   localparam int D = 5;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic          clear = 1'b0;
   logic [W-1:0]  din = '0;
   logic [W-1:0]  top;
   logic [W-1:0]  dout;
   logic          dout_valid;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          overflow;
   logic          underflow;

   param_stack #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop),
      .clear(clear), .din(din), .top(top), .dout(dout),
      .dout_valid(dout_valid), .count(count), .empty(empty),
      .full(full), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cnt;
      logic [W-1:0] top;
      logic [W-1:0] dout;
      bit         dv;
      bit         ovf;
      bit         unf;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] dq[$];
   int           n_chk = 0;
   int           n_pass = 0;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", n, act, exp);
   endtask

   // state monitor: one expectation per clock edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("count", 32'(count), 32'(e.cnt));
            chk("top", 32'(top), 32'(e.top));
            chk("dout", 32'(dout), 32'(e.dout));
            chk("dout_valid", 32'(dout_valid), 32'(e.dv));
            chk("empty", 32'(empty), 32'(e.cnt == 0));
            chk("full", 32'(full), 32'(e.cnt == D));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("underflow", 32'(underflow), 32'(e.unf));
         end
      end
   end

   // pop-data monitor: consumes an expected value on each dout_valid
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (dout_valid) begin
            if (dq.size() == 0) chk("dout_unexpected", 32'(dout), 32'hx);
            else chk("dout_pop", 32'(dout), 32'(dq.pop_front()));
         end
      end
   end

   task automatic step(input bit p, input bit po, input bit c,
                       input logic [W-1:0] d, input int cnt,
                       input logic [W-1:0] t, input logic [W-1:0] o,
                       input bit dv, input bit ov, input bit un);
      exp_t e;
      @(negedge clk);
      push = p;
      pop = po;
      clear = c;
      din = d;
      e.cnt = cnt;
      e.top = t;
      e.dout = o;
      e.dv = dv;
      e.ovf = ov;
      e.unf = un;
      sb.push_back(e);
      if (dv) dq.push_back(o);
      @(posedge clk);
   endtask

   task automatic check_reset_vals();
      chk("rst_count", 32'(count), 0);
      chk("rst_top", 32'(top), 0);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_dv", 32'(dout_valid), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_unf", 32'(underflow), 0);
   endtask

   logic [W-1:0] mq[$];
   logic [W-1:0] md;
   bit           mdv, mo, mu;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_vals();

      //   p  po c  din    cnt top    dout   dv ov un
      step(1, 0, 0, 24'hA, 1, 24'hA, 24'h0, 0, 0, 0);
      step(1, 0, 0, 24'hB, 2, 24'hB, 24'h0, 0, 0, 0);
      step(1, 0, 0, 24'hC, 3, 24'hC, 24'h0, 0, 0, 0);
      step(0, 1, 0, 24'h0, 2, 24'hB, 24'hC, 1, 0, 0);
      step(0, 1, 0, 24'h0, 1, 24'hA, 24'hB, 1, 0, 0);
      step(0, 1, 0, 24'h0, 0, 24'h0, 24'hA, 1, 0, 0);
      step(1, 0, 0, 24'h1, 1, 24'h1, 24'hA, 0, 0, 0);
      step(1, 0, 0, 24'h2, 2, 24'h2, 24'hA, 0, 0, 0);
      step(1, 0, 0, 24'h3, 3, 24'h3, 24'hA, 0, 0, 0);
      step(1, 0, 0, 24'h4, 4, 24'h4, 24'hA, 0, 0, 0);
      step(1, 0, 0, 24'h5, 5, 24'h5, 24'hA, 0, 0, 0);
      step(1, 0, 0, 24'h6, 5, 24'h5, 24'hA, 0, 1, 0);
      step(1, 1, 0, 24'h9, 5, 24'h9, 24'h5, 1, 1, 0);
      step(0, 1, 0, 24'h0, 4, 24'h4, 24'h9, 1, 1, 0);
      step(0, 0, 1, 24'h0, 0, 24'h0, 24'h9, 0, 0, 0);
      step(0, 1, 0, 24'h0, 0, 24'h0, 24'h9, 0, 0, 1);
      step(1, 1, 0, 24'h7, 1, 24'h7, 24'h9, 0, 0, 1);
      step(0, 0, 0, 24'h0, 1, 24'h7, 24'h9, 0, 0, 1);
      step(1, 0, 0, 24'h1, 2, 24'h1, 24'h9, 0, 0, 1);
      step(1, 0, 0, 24'h2, 3, 24'h2, 24'h9, 0, 0, 1);
      step(1, 0, 0, 24'h3, 4, 24'h3, 24'h9, 0, 0, 1);
      step(1, 0, 1, 24'h8, 0, 24'h0, 24'h9, 0, 0, 0);
      step(1, 0, 0, 24'h5, 1, 24'h5, 24'h9, 0, 0, 0);
      step(1, 1, 0, 24'h6, 1, 24'h6, 24'h5, 1, 0, 0);
      step(1, 0, 0, 24'h1, 2, 24'h1, 24'h5, 0, 0, 0);
      step(1, 0, 0, 24'h2, 3, 24'h2, 24'h5, 0, 0, 0);

      // asynchronous reset between edges, with push still requested
      #2;
      reset = 1'b1;
      push = 1'b1;
      din = 24'h3;
      #1;
      check_reset_vals();
      push = 1'b0;
      #1;
      reset = 1'b0;
      step(0, 1, 0, 24'h0, 0, 24'h0, 24'h0, 0, 0, 1);

      @(negedge clk);
      push = 0;
      pop = 0;
      clear = 0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      mq.delete();
      md = '0;
      mdv = 0;
      mo = 0;
      mu = 0;

      for (int i = 0; i < 400; i++) begin
         bit p, po, c;
         logic [W-1:0] d;
         p = ($urandom_range(0, 99) < 55);
         po = ($urandom_range(0, 99) < 50);
         c = ($urandom_range(0, 99) < 4);
         d = W'($urandom);
         if (c) begin
            mq.delete();
            mo = 0;
            mu = 0;
            mdv = 0;
         end else if (p && po) begin
            if (mq.size() > 0) begin
               md = mq[$];
               mq[$] = d;
               mdv = 1;
            end else begin
               mq.push_back(d);
               mdv = 0;
            end
         end else if (p) begin
            if (mq.size() == D) mo = 1;
            else mq.push_back(d);
            mdv = 0;
         end else if (po) begin
            if (mq.size() > 0) begin
               md = mq.pop_back();
               mdv = 1;
            end else begin
               mu = 1;
               mdv = 0;
            end
         end else begin
            mdv = 0;
         end
         step(p, po, c, d, mq.size(),
              (mq.size() > 0) ? mq[$] : '0, md, mdv, mo, mu);
      end

      @(negedge clk);
      push = 0;
      pop = 0;
      clear = 0;
      repeat (2) @(posedge clk);
      #2;
      chk("sb_drained", 32'(sb.size() + dq.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/param_stack.md
# param_stack

Parametrised LIFO stack for the instruction path, the successor to the fixed 24×256 instruction stack. It accepts a push or pop on every clock with no idle cycle between operations and supports a simultaneous push+pop that replaces the top entry. It exposes the current top-of-stack combinationally plus a registered pop-data port, occupancy, full/empty flags, and sticky overflow/underflow error flags. It sits between the instruction decoder (pushes) and the evaluator (pops/peeks).

## Interface
- WIDTH, 24, entry width in bits (≥1)
- DEPTH, 256, number of entries (≥2, need not be a power of two)
- CW, $clog2(DEPTH+1), width of `count` (derived, not overridden)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- push  in  1  write `din` onto stack this cycle
- pop  in  1  remove top entry this cycle
- clear  in  1  synchronous flush; highest priority
- din  in  WIDTH  data to push
- top  out  WIDTH  current top entry; 0 when empty
- dout  out  WIDTH  value removed by the last accepted pop (registered)
- dout_valid  out  1  one-cycle pulse, cycle after an accepted pop
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Storage: mem[0..DEPTH-1], no reset on memory contents. count is the write pointer; the top entry is mem[count-1].
- Priority per edge: reset > clear > push/pop.
- clear: count←0, overflow←0, underflow←0, dout_valid←0; dout holds its value; memory untouched.
- push only:
  - not full: mem[count]←din, count+1.
  - full: no state change except overflow←1.
- pop only:
  - not empty: dout←mem[count-1], dout_valid←1, count-1.
  - empty: dout_valid←0, underflow←1.
- push and pop together:
  - not empty: dout←mem[count-1], dout_valid←1, mem[count-1]←din, count unchanged (replace). Allowed when full; no overflow.
  - empty: treated as push only (count→1, top=din). Pop is ignored, and underflow is not set.
- Neither asserted: state held, dout_valid←0.
- `top`, `empty`, `full` are combinational from count and memory. They reflect post-edge state.
- Error flags stay set until reset or clear and never block further operations.
- count arithmetic is CW bits and never wraps: increments are blocked at DEPTH and decrements at 0.

## Timing
- Reset values: count=0, top=0, dout=0, dout_valid=0, empty=1, full=0, overflow=0, underflow=0.
- Reset asserted mid-operation takes effect immediately (asynchronous). Any push/pop in that cycle is lost.
- Push-to-top latency: 1 edge. After the edge that accepts a push, top==din.
- Pop-to-dout latency: 1 edge. dout/dout_valid update on the same edge that decrements count.
- Throughput: one operation per cycle. Back-to-back push, pop, and push+pop sequences need no bubbles.
- Flags update on the same edge as count. overflow/underflow assert on the edge of the offending request.

## Test plan
- Reset, then push 0xA, 0xB, 0xC on consecutive cycles -> count=3, top=0xC, empty=0; pop ×3 back-to-back -> dout=0xC,0xB,0xA with dout_valid high 3 cycles, then count=0, empty=1, top=0.
- Fill to DEPTH (use DEPTH=4): push 1..4 -> full=1; push 5 -> overflow=1, count=4, top=4; push+pop with din=9 -> dout=4, top=9, count=4, overflow still 1.
- Pop on empty -> underflow=1, dout_valid=0, count=0; push+pop on empty with din=7 -> count=1, top=7, dout_valid=0.
- Push 1,2,3, assert clear with push=1 din=8 -> count=0, overflow/underflow=0, push ignored; next push 5 -> top=5, count=1.
- Push 1,2 then assert reset mid-cycle (between edges) -> all outputs at reset values immediately; after release, pop -> underflow=1.
- Randomised push/pop/clear vs. reference queue model, WIDTH=24, DEPTH=5 (non-power-of-two) -> top, dout, count and flags match every cycle.
